// File: rtl/sram_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_word_packer
//  Description : Packs a byte-wide SRAM write stream (from the SPI RAM loader)
//                into 32-bit little-endian word writes with byte-lane selects.
//                A 2-entry output queue with an ack handshake absorbs RAM-side
//                stalls; a word pushed into a full queue without a
//                simultaneous pop is dropped and flagged on a sticky overflow
//                output.
//                Optional macro SRAM_WORD_PACKER_FULL_WORD_EN: every pushed
//                word carries sel=4'hF, with missing lanes written as 8'h00.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_word_packer #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_wen,
    output logic [AW-3:0] o_waddr,
    output logic [31:0]   o_wdata,
    output logic [3:0]    o_sel,
    output logic          o_wen,
    input  logic          i_ack,
    output logic          o_busy,
    output logic          o_overflow
);

    localparam int             c_cw      = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_to_last = c_cw'(TIMEOUT - 1);

    // Accumulator state
    logic            r_acc_valid;
    logic [AW-3:0]   r_acc_addr;
    logic [31:0]     r_acc_data;
    logic [3:0]      r_acc_sel;
    logic [c_cw-1:0] r_idle_cnt;

    // Output queue state
    logic [AW-3:0]   r_q_addr [2];
    logic [31:0]     r_q_data [2];
    logic [3:0]      r_q_sel  [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            r_overflow;

    // Incoming byte decode
    logic [1:0]      w_lane;
    logic [AW-3:0]   w_word;
    logic [3:0]      w_lane_sel;
    logic [31:0]     w_lane_mask;
    logic [31:0]     w_byte_data;
    logic [31:0]     w_merge_data;
    logic [3:0]      w_merge_sel;
    logic            w_same_word;

    // Next accumulator state and push request
    logic            w_nxt_valid;
    logic [AW-3:0]   w_nxt_addr;
    logic [31:0]     w_nxt_data;
    logic [3:0]      w_nxt_sel;
    logic            w_push;
    logic [AW-3:0]   w_push_addr;
    logic [31:0]     w_push_data;
    logic [3:0]      w_push_sel;
    logic [3:0]      w_push_sel_q;

    // Queue control
    logic            w_full;
    logic            w_pop;
    logic            w_accept;
    logic            w_drop;

    // Byte lane decode and merge of the incoming byte into the accumulator
    always_comb begin
        w_lane       = i_waddr[1:0];
        w_word       = i_waddr[AW-1:2];
        w_lane_sel   = 4'b0001 << w_lane;
        w_lane_mask  = {{8{w_lane_sel[3]}}, {8{w_lane_sel[2]}},
                        {8{w_lane_sel[1]}}, {8{w_lane_sel[0]}}};
        w_byte_data  = {24'd0, i_wdata} << {w_lane, 3'b000};
        w_merge_data = (r_acc_data & ~w_lane_mask) | w_byte_data;
        w_merge_sel  = r_acc_sel | w_lane_sel;
        w_same_word  = r_acc_valid && (r_acc_addr == w_word);
    end

    // Accumulator next state and single push source per cycle
    always_comb begin
        w_nxt_valid = r_acc_valid;
        w_nxt_addr  = r_acc_addr;
        w_nxt_data  = r_acc_data;
        w_nxt_sel   = r_acc_sel;
        w_push      = 1'b0;
        w_push_addr = r_acc_addr;
        w_push_data = r_acc_data;
        w_push_sel  = r_acc_sel;
        if (i_wen) begin
            if (w_same_word) begin
                if (w_merge_sel == 4'hF) begin
                    // Completed word leaves immediately; accumulator empties
                    w_push      = 1'b1;
                    w_push_data = w_merge_data;
                    w_push_sel  = w_merge_sel;
                    w_nxt_valid = 1'b0;
                    w_nxt_data  = 32'd0;
                    w_nxt_sel   = 4'd0;
                end else begin
                    w_nxt_data = w_merge_data;
                    w_nxt_sel  = w_merge_sel;
                end
            end else begin
                // Different word evicts the old partial word (if any);
                // a single fresh byte can never complete a word.
                w_push      = r_acc_valid;
                w_nxt_valid = 1'b1;
                w_nxt_addr  = w_word;
                w_nxt_data  = w_byte_data;
                w_nxt_sel   = w_lane_sel;
            end
        end else if (r_acc_valid && (r_idle_cnt == c_to_last)) begin
            // TIMEOUT-th consecutive idle cycle: flush the partial word
            w_push      = 1'b1;
            w_nxt_valid = 1'b0;
            w_nxt_data  = 32'd0;
            w_nxt_sel   = 4'd0;
        end
    end

`ifdef SRAM_WORD_PACKER_FULL_WORD_EN
    // Missing lanes already hold zero, so forcing all enables writes 8'h00
    assign w_push_sel_q = 4'hF;
`else
    assign w_push_sel_q = w_push_sel;
`endif

    assign w_full   = (r_count == 2'd2);
    assign w_pop    = o_wen & i_ack;
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    // Accumulator and idle-timeout counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_valid <= 1'b0;
            r_acc_addr  <= '0;
            r_acc_data  <= 32'd0;
            r_acc_sel   <= 4'd0;
            r_idle_cnt  <= '0;
        end else begin
            r_acc_valid <= w_nxt_valid;
            r_acc_addr  <= w_nxt_addr;
            r_acc_data  <= w_nxt_data;
            r_acc_sel   <= w_nxt_sel;
            if (i_wen || !w_nxt_valid) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    // Two-entry output FIFO with sticky overflow on dropped pushes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_q_addr[i] <= '0;
                r_q_data[i] <= 32'd0;
                r_q_sel[i]  <= 4'd0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_q_addr[r_wr_ptr] <= w_push_addr;
                r_q_data[r_wr_ptr] <= w_push_data;
                r_q_sel[r_wr_ptr]  <= w_push_sel_q;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - 2'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head-of-queue presentation; outputs read zero while the queue is empty
    assign o_wen      = (r_count != 2'd0);
    assign o_waddr    = o_wen ? r_q_addr[r_rd_ptr] : '0;
    assign o_wdata    = o_wen ? r_q_data[r_rd_ptr] : 32'd0;
    assign o_sel      = o_wen ? r_q_sel[r_rd_ptr]  : 4'd0;
    assign o_busy     = r_acc_valid | o_wen;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sram_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_word_packer
//  Description : Directed self-checking bench for sram_word_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_word_packer;

    localparam int AW = 16;
    localparam int TO = 16;

`ifdef SRAM_WORD_PACKER_FULL_WORD_EN
    localparam logic [3:0] c_fw = 1'b1;
`else
    localparam logic [3:0] c_fw = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          wen;
    logic [AW-3:0] o_waddr;
    logic [31:0]   o_wdata;
    logic [3:0]    o_sel;
    logic          o_wen;
    logic          ack;
    logic          o_busy;
    logic          o_overflow;

    int errors = 0;
    int checks = 0;
    logic seen;

    sram_word_packer #(.AW(AW), .TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_waddr   (waddr),
        .i_wdata   (wdata),
        .i_wen     (wen),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata),
        .o_sel     (o_sel),
        .o_wen     (o_wen),
        .i_ack     (ack),
        .o_busy    (o_busy),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [AW-1:0] a, input logic [7:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        step();
        wen   = 1'b0;
    endtask

    function automatic logic [3:0] esel(input logic [3:0] s);
        return (c_fw != 4'd0) ? 4'hF : s;
    endfunction

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; ack = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_wen",   32'(o_wen),      32'd0);
        chk("rst_sel",   32'(o_sel),      32'd0);
        chk("rst_wdata", o_wdata,         32'd0);
        chk("rst_waddr", 32'(o_waddr),    32'd0);
        chk("rst_busy",  32'(o_busy),     32'd0);
        chk("rst_ovf",   32'(o_overflow), 32'd0);

        // Full word on consecutive cycles
        put(16'd0, 8'h11); put(16'd1, 8'h22); put(16'd2, 8'h33);
        chk("t1_nowen_yet", 32'(o_wen),  32'd0);
        chk("t1_busy_acc",  32'(o_busy), 32'd1);
        put(16'd3, 8'h44);
        chk("t1_wen",   32'(o_wen),   32'd1);
        chk("t1_waddr", 32'(o_waddr), 32'd0);
        chk("t1_wdata", o_wdata,      32'h44332211);
        chk("t1_sel",   32'(o_sel),   32'hF);
        step();
        chk("t1_wen_done", 32'(o_wen),  32'd0);
        chk("t1_busy_done", 32'(o_busy), 32'd0);

        // Partial word flushed after TO idle cycles
        put(16'd5, 8'hAA); put(16'd6, 8'hBB);
        seen = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            if (o_wen) seen = 1'b1;
            step();
        end
        if (o_wen) seen = 1'b1;
        chk("t2_no_early_wen", 32'(seen), 32'd0);
        step();
        chk("t2_wen",   32'(o_wen),   32'd1);
        chk("t2_waddr", 32'(o_waddr), 32'd1);
        chk("t2_wdata", o_wdata,      32'h00BBAA00);
        chk("t2_sel",   32'(o_sel),   32'(esel(4'b0110)));
        step();
        chk("t2_wen_done", 32'(o_wen), 32'd0);

        // Word change evicts the partial word
        put(16'd4, 8'h5A);
        put(16'd16, 8'hC3);
        chk("t3_wen",   32'(o_wen),   32'd1);
        chk("t3_waddr", 32'(o_waddr), 32'd1);
        chk("t3_wdata", o_wdata,      32'h0000005A);
        chk("t3_sel",   32'(o_sel),   32'(esel(4'b0001)));
        step();
        chk("t3_wen_popped", 32'(o_wen),  32'd0);
        chk("t3_busy_pend",  32'(o_busy), 32'd1);
        for (int i = 0; i < TO - 2; i++) step();
        chk("t3_pend_not_yet", 32'(o_wen), 32'd0);
        step();
        chk("t3_pend_wen",   32'(o_wen),   32'd1);
        chk("t3_pend_waddr", 32'(o_waddr), 32'd4);
        chk("t3_pend_wdata", o_wdata,      32'h000000C3);
        chk("t3_pend_sel",   32'(o_sel),   32'(esel(4'b0001)));
        step();
        chk("t3_idle", 32'(o_busy), 32'd0);

        // Overflow: three full words with RAM stalled
        ack = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (w == 2 && b == 3) chk("t4_ovf_before", 32'(o_overflow), 32'd0);
                put(AW'(w * 4 + b), 8'((w + 1) * 16 + b));
            end
        end
        chk("t4_ovf",   32'(o_overflow), 32'd1);
        chk("t4_wen",   32'(o_wen),      32'd1);
        chk("t4_waddr0", 32'(o_waddr),   32'd0);
        chk("t4_wdata0", o_wdata,        32'h13121110);
        step();
        chk("t4_stall_hold", 32'(o_waddr), 32'd0);
        ack = 1'b1;
        step();
        chk("t4_wen1",   32'(o_wen),   32'd1);
        chk("t4_waddr1", 32'(o_waddr), 32'd1);
        chk("t4_wdata1", o_wdata,      32'h23222120);
        step();
        chk("t4_no_third", 32'(o_wen),      32'd0);
        chk("t4_ovf_hold", 32'(o_overflow), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t4_ovf_cleared", 32'(o_overflow), 32'd0);

        // Repeated lane overwrite
        put(16'd0, 8'h01); put(16'd0, 8'h02); put(16'd1, 8'h03); put(16'd2, 8'h04);
        chk("t5_no_early", 32'(o_wen), 32'd0);
        put(16'd3, 8'h05);
        chk("t5_wen",   32'(o_wen), 32'd1);
        chk("t5_wdata", o_wdata,    32'h05040302);
        chk("t5_sel",   32'(o_sel), 32'hF);
        step();
        chk("t5_done", 32'(o_wen), 32'd0);

        // Reset mid-word discards pending bytes
        put(16'd0, 8'h77); put(16'd1, 8'h88);
        rst = 1'b1; step(); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TO + 5; i++) begin
            if (o_wen || o_busy || o_sel != 4'd0 || o_wdata != 32'd0) seen = 1'b1;
            step();
        end
        chk("t6_never_active", 32'(seen),   32'd0);
        chk("t6_wen",          32'(o_wen),  32'd0);
        chk("t6_busy",         32'(o_busy), 32'd0);
        chk("t6_wdata",        o_wdata,     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_word_packer.md
Name: sram_word_packer

Overview:
- Sits directly downstream of the SPI RAM loader.
- Consumes its byte-wide SRAM write stream (byte address, data, write strobe) and packs the bytes into 32-bit little-endian word writes with byte-lane selects, for a 32-bit-wide RAM/bus port.
- Adds a 2-entry output queue with an ack handshake so that RAM-side stalls do not lose data, up to the queue depth.

Parameters:
- AW, 16, byte address width of the incoming stream; must be >= 3.
- TIMEOUT, 255, idle cycles after which a partial word is flushed; must be >= 1.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_waddr  input  AW  byte write address from loader
- i_wdata  input  8  byte write data from loader
- i_wen  input  1  byte write strobe, one byte per asserted cycle, no backpressure
- o_waddr  output  AW-2  word address
- o_wdata  output  32  word data; lane k occupies bits 8k+7:8k
- o_sel  output  4  byte-lane enables
- o_wen  output  1  word write request, held until acked
- i_ack  input  1  RAM accepts the current word
- o_busy  output  1  accumulator or queue holds data
- o_overflow  output  1  sticky: a word was dropped because the queue was full

Behaviour:
- Reset: o_wen=0, o_sel=0, o_wdata=0, o_waddr=0, o_busy=0, o_overflow=0. Accumulator and queue are emptied and the timeout counter cleared. Reset mid-operation discards all pending bytes; no write is issued.
- Incoming byte on i_wen: word = i_waddr[AW-1:2], lane = i_waddr[1:0].
- Accumulator empty: load word, place byte in its lane, acc_sel = 1<<lane.
- Accumulator valid, same word: merge the byte. A repeated lane overwrites its data; sel is ORed.
- Accumulator valid, different word: push the old accumulator to the queue, then load the new byte, both in the same cycle.
- Full word: if acc_sel becomes 4'hF after a merge, the word is pushed that same cycle and the accumulator is cleared.
- Timeout: the counter resets on every i_wen and counts while the accumulator is valid and i_wen=0. When it reaches TIMEOUT, the partial word is pushed and the accumulator cleared. i_wen in the same cycle takes priority: no timeout push, counter cleared.
- At most one push per cycle.
- Queue: 2-entry FIFO of {addr, data, sel}.
  - o_wen = queue not empty; outputs show the head entry, stable until o_wen & i_ack.
  - Pop on o_wen & i_ack.
  - Push and pop in the same cycle are legal at any fill level, including full; the entry is accepted.
  - Push while full without a pop: the word is dropped and o_overflow is set until reset.
- Latency: the byte completing a word in cycle N gives o_wen=1 in cycle N+1 when the queue was empty. The next entry is presented the cycle after an ack.
- Unused lanes: o_wdata lanes whose sel bit is 0 are driven 0.
- o_busy = accumulator valid | queue not empty (registered or combinational from state, no extra latency).
- Address wrap: no special case; the word address is used as given.

Optional Feature:
- Macro: SRAM_WORD_PACKER_FULL_WORD_EN.
- Defined: every pushed word has o_sel=4'hF. Missing lanes are written as 8'h00, for RAMs without byte enables.
- Undefined: o_sel reflects exactly the lanes received, as described above.

Test Plan:
- i_ack tied 1; bytes 11,22,33,44 to addr 0..3 on consecutive cycles -> one write, cycle after the 4th byte: o_waddr=0, o_wdata=32'h44332211, o_sel=4'hF. o_busy drops after the ack.
- Bytes AA@5, BB@6, then idle -> no write until TIMEOUT idle cycles, then o_waddr=1, o_wdata=32'h00BBAA00, o_sel=4'b0110. With SRAM_WORD_PACKER_FULL_WORD_EN: same data, o_sel=4'hF.
- Byte 5A@4, next cycle byte C3@16 -> word 1 pushed in the second byte's cycle: o_waddr=1, o_wdata=32'h0000005A, o_sel=4'b0001. Word 4 is pending with sel 4'b0001.
- i_ack=0; write 3 full words to addr 0, 4, 8 -> words 0 and 1 queued, word 2 dropped, o_overflow=1. Then raise i_ack -> exactly 2 writes issue, addr 0 then 1; o_overflow stays 1.
- Bytes 01@0 then 02@0 then 03@1,04@2,05@3 -> single write: o_wdata=32'h05040302, o_sel=4'hF.
- Bytes @0,@1, then i_rst for 1 cycle, then idle for TIMEOUT+5 cycles -> no o_wen ever; all outputs 0.
